// File: rtl/snake_dir_ctrl.sv
// Per-player snake direction controller: button sync/debounce/edge-detect,
// a small pending-turn FIFO per player, and one queued turn applied per game tick.
module snake_dir_ctrl #(
   parameter int         N_PLAYERS       = 2,
   parameter int         QUEUE_DEPTH     = 2,
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [1:0] INIT_DIR        = 2'b11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_PLAYERS-1:0]   up,
   input  logic [N_PLAYERS-1:0]   down,
   input  logic [N_PLAYERS-1:0]   left,
   input  logic [N_PLAYERS-1:0]   right,
   input  logic                   tick,
   output logic [2*N_PLAYERS-1:0] next_pos,
   output logic [N_PLAYERS-1:0]   turn_valid,
   output logic [N_PLAYERS-1:0]   q_full
);

   localparam int NB    = 4 * N_PLAYERS;
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   // Button vector layout: bit b*N_PLAYERS+p, b = 0 up, 1 down, 2 left, 3 right.
   logic [NB-1:0] raw_all;
   assign raw_all = {right, left, down, up};

   logic [NB-1:0]   sync1_q, sync1_d;
   logic [NB-1:0]   sync2_q, sync2_d;
   logic [NB-1:0]   deb_q,   deb_d;
   logic [NB-1:0]   req_q,   req_d;
   logic [DB_W-1:0] cnt_q [NB];
   logic [DB_W-1:0] cnt_d [NB];

   logic [1:0]       mem_q  [N_PLAYERS][QUEUE_DEPTH];
   logic [1:0]       mem_d  [N_PLAYERS][QUEUE_DEPTH];
   logic [PTR_W-1:0] rd_q   [N_PLAYERS];
   logic [PTR_W-1:0] rd_d   [N_PLAYERS];
   logic [PTR_W-1:0] wr_q   [N_PLAYERS];
   logic [PTR_W-1:0] wr_d   [N_PLAYERS];
   logic [CNT_W-1:0] fcnt_q [N_PLAYERS];
   logic [CNT_W-1:0] fcnt_d [N_PLAYERS];
   logic [1:0]       tail_q [N_PLAYERS];
   logic [1:0]       tail_d [N_PLAYERS];
   logic [1:0]       pos_q  [N_PLAYERS];
   logic [1:0]       pos_d  [N_PLAYERS];
   logic [N_PLAYERS-1:0] tv_q,   tv_d;
   logic [N_PLAYERS-1:0] full_q, full_d;

   logic [N_PLAYERS-1:0] has_req;
   logic [N_PLAYERS-1:0] push;
   logic [N_PLAYERS-1:0] pop;
   logic [1:0]           req_dir [N_PLAYERS];
   logic [1:0]           ref_dir [N_PLAYERS];

   // The debounced level flips on the last stable sample; the request pulse is
   // registered in the same edge so it reaches the FIFO one cycle later.
   always_comb begin
      sync1_d = raw_all;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      req_d   = '0;
      for (int i = 0; i < NB; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
         req_d[i] = deb_d[i] & ~deb_q[i];
      end
   end

   always_comb begin
      has_req = '0;
      push    = '0;
      pop     = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         req_dir[p] = DIR_UP;
         if (req_q[p]) begin
            has_req[p] = 1'b1;
            req_dir[p] = DIR_UP;
         end else if (req_q[N_PLAYERS + p]) begin
            has_req[p] = 1'b1;
            req_dir[p] = DIR_DOWN;
         end else if (req_q[2*N_PLAYERS + p]) begin
            has_req[p] = 1'b1;
            req_dir[p] = DIR_LEFT;
         end else if (req_q[3*N_PLAYERS + p]) begin
            has_req[p] = 1'b1;
            req_dir[p] = DIR_RIGHT;
         end
         // Compare against the last turn the snake will have made, not its current heading.
         ref_dir[p] = (fcnt_q[p] != '0) ? tail_q[p] : pos_q[p];
         pop[p]     = tick && (fcnt_q[p] != '0);
         push[p]    = has_req[p]
                      && (req_dir[p] != ref_dir[p])
                      && (req_dir[p] != (ref_dir[p] ^ 2'b01))
                      && ((fcnt_q[p] != CNT_FULL) || pop[p]);
      end
   end

   always_comb begin
      mem_d  = mem_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      fcnt_d = fcnt_q;
      tail_d = tail_q;
      pos_d  = pos_q;
      tv_d   = '0;
      full_d = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (pop[p]) begin
            pos_d[p] = mem_q[p][rd_q[p]];
            rd_d[p]  = ptr_inc(rd_q[p]);
         end
         if (push[p]) begin
            mem_d[p][wr_q[p]] = req_dir[p];
            wr_d[p]           = ptr_inc(wr_q[p]);
            tail_d[p]         = req_dir[p];
         end
         case ({push[p], pop[p]})
            2'b10:   fcnt_d[p] = fcnt_q[p] + 1'b1;
            2'b01:   fcnt_d[p] = fcnt_q[p] - 1'b1;
            default: fcnt_d[p] = fcnt_q[p];
         endcase
         tv_d[p]   = pop[p];
         full_d[p] = (fcnt_d[p] == CNT_FULL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         req_q   <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt_q[i] <= '0;
         end
         for (int p = 0; p < N_PLAYERS; p++) begin
            rd_q[p]   <= '0;
            wr_q[p]   <= '0;
            fcnt_q[p] <= '0;
            tail_q[p] <= INIT_DIR;
            pos_q[p]  <= INIT_DIR;
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
               mem_q[p][k] <= '0;
            end
         end
         tv_q   <= '0;
         full_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fcnt_q  <= fcnt_d;
         tail_q  <= tail_d;
         pos_q   <= pos_d;
         tv_q    <= tv_d;
         full_q  <= full_d;
      end
   end

   always_comb begin
      next_pos = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         next_pos[2*p +: 2] = pos_q[p];
      end
   end

   assign turn_valid = tv_q;
   assign q_full     = full_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: scripted button presses and ticks, with a per-player
// scoreboard of expected turns that is drained whenever turn_valid pulses.
module tb_snake_dir_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] up = '0, down = '0, left = '0, right = '0;
   logic       tick = 1'b0;
   logic [3:0] next_pos;
   logic [1:0] turn_valid;
   logic [1:0] q_full;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_q0 [$];
   logic [1:0] exp_q1 [$];
   logic [1:0] mon_e;

   snake_dir_ctrl #(
      .N_PLAYERS(2), .QUEUE_DEPTH(2), .DEBOUNCE_CYCLES(4), .INIT_DIR(2'b11)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .up(up), .down(down), .left(left), .right(right),
      .tick(tick),
      .next_pos(next_pos), .turn_valid(turn_valid), .q_full(q_full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Scoreboard drain: every turn pulse must match the oldest expected turn.
   always @(negedge clk) begin
      if (rst_n) begin
         if (turn_valid[0]) begin
            total++;
            if (exp_q0.size() == 0) begin
               bad++;
               $display("FAIL sb_p0: unexpected turn, got %b, expected none", next_pos[1:0]);
            end else begin
               mon_e = exp_q0.pop_front();
               if (next_pos[1:0] !== mon_e) begin
                  bad++;
                  $display("FAIL sb_p0: got %b expected %b", next_pos[1:0], mon_e);
               end
            end
         end
         if (turn_valid[1]) begin
            total++;
            if (exp_q1.size() == 0) begin
               bad++;
               $display("FAIL sb_p1: unexpected turn, got %b, expected none", next_pos[3:2]);
            end else begin
               mon_e = exp_q1.pop_front();
               if (next_pos[3:2] !== mon_e) begin
                  bad++;
                  $display("FAIL sb_p1: got %b expected %b", next_pos[3:2], mon_e);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [1:0] m_up, input logic [1:0] m_down,
                        input logic [1:0] m_left, input logic [1:0] m_right,
                        input int hold);
      up = m_up; down = m_down; left = m_left; right = m_right;
      idle(hold);
      up = '0; down = '0; left = '0; right = '0;
      idle(10);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL reset_hold_pos: got %b expected 1111", next_pos); end
      rst_n = 1'b1;
      idle(5);
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL reset_pos: got %b expected 1111", next_pos); end
      total++;
      if (turn_valid !== 2'b00) begin bad++; $display("FAIL reset_tv: got %b expected 00", turn_valid); end
      total++;
      if (q_full !== 2'b00) begin bad++; $display("FAIL reset_full: got %b expected 00", q_full); end
   endtask

   task automatic test_single_turn();
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b00, 2'b00, 2'b00, 10);
      total++;
      if (q_full !== 2'b00) begin bad++; $display("FAIL single_full: got %b expected 00", q_full); end
      do_tick();
      total++;
      if (next_pos !== 4'b1100) begin bad++; $display("FAIL single_pos: got %b expected 1100", next_pos); end
      total++;
      if (turn_valid !== 2'b01) begin bad++; $display("FAIL single_tv: got %b expected 01", turn_valid); end
      idle(1);
      total++;
      if (turn_valid !== 2'b00) begin bad++; $display("FAIL single_tv_pulse: got %b expected 00", turn_valid); end
      exp_q0.push_back(2'b11);
      press(2'b00, 2'b00, 2'b00, 2'b01, 10);
      do_tick();
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL single_back_right: got %b expected 1111", next_pos); end
   endtask

   task automatic test_reverse();
      press(2'b00, 2'b00, 2'b01, 2'b00, 10);
      do_tick();
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL reverse_pos: got %b expected 1111", next_pos); end
      total++;
      if (turn_valid !== 2'b00) begin bad++; $display("FAIL reverse_tv: got %b expected 00", turn_valid); end
      press(2'b00, 2'b00, 2'b00, 2'b01, 10);
      do_tick();
      total++;
      if (turn_valid !== 2'b00) begin bad++; $display("FAIL redundant_tv: got %b expected 00", turn_valid); end
   endtask

   task automatic test_double_turn();
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b00, 2'b00, 2'b00, 10);
      exp_q0.push_back(2'b10);
      press(2'b00, 2'b00, 2'b01, 2'b00, 10);
      total++;
      if (q_full !== 2'b01) begin bad++; $display("FAIL double_full: got %b expected 01", q_full); end
      press(2'b00, 2'b01, 2'b00, 2'b00, 10);
      total++;
      if (q_full !== 2'b01) begin bad++; $display("FAIL double_full_drop: got %b expected 01", q_full); end
      do_tick();
      total++;
      if (next_pos !== 4'b1100 || turn_valid !== 2'b01 || q_full !== 2'b00) begin
         bad++; $display("FAIL double_t1: got pos=%b tv=%b full=%b expected 1100 01 00", next_pos, turn_valid, q_full);
      end
      do_tick();
      total++;
      if (next_pos !== 4'b1110 || turn_valid !== 2'b01) begin
         bad++; $display("FAIL double_t2: got pos=%b tv=%b expected 1110 01", next_pos, turn_valid);
      end
      do_tick();
      total++;
      if (next_pos !== 4'b1110 || turn_valid !== 2'b00) begin
         bad++; $display("FAIL double_t3: got pos=%b tv=%b expected 1110 00", next_pos, turn_valid);
      end
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b00, 2'b00, 2'b00, 10);
      exp_q0.push_back(2'b11);
      press(2'b00, 2'b00, 2'b00, 2'b01, 10);
      do_tick();
      do_tick();
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL double_restore: got %b expected 1111", next_pos); end
   endtask

   task automatic test_glitch();
      press(2'b10, 2'b00, 2'b00, 2'b00, 3);
      do_tick();
      total++;
      if (next_pos !== 4'b1111 || turn_valid !== 2'b00) begin
         bad++; $display("FAIL glitch3: got pos=%b tv=%b expected 1111 00", next_pos, turn_valid);
      end
      exp_q1.push_back(2'b00);
      press(2'b10, 2'b00, 2'b00, 2'b00, 4);
      do_tick();
      total++;
      if (next_pos !== 4'b0011 || turn_valid !== 2'b10) begin
         bad++; $display("FAIL stable4: got pos=%b tv=%b expected 0011 10", next_pos, turn_valid);
      end
      exp_q1.push_back(2'b11);
      press(2'b00, 2'b00, 2'b00, 2'b10, 10);
      do_tick();
      total++;
      if (next_pos !== 4'b1111) begin bad++; $display("FAIL glitch_restore: got %b expected 1111", next_pos); end
   endtask

   task automatic test_priority_reset();
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b01, 2'b00, 2'b00, 10);
      do_tick();
      total++;
      if (next_pos !== 4'b1100) begin bad++; $display("FAIL prio_pos: got %b expected 1100", next_pos); end
      do_tick();
      total++;
      if (turn_valid !== 2'b00) begin bad++; $display("FAIL prio_single: got tv=%b expected 00", turn_valid); end
      exp_q0.push_back(2'b10);
      press(2'b00, 2'b00, 2'b01, 2'b00, 10);
      rst_n = 1'b0;
      exp_q0.delete();
      #1;
      total++;
      if (next_pos !== 4'b1111 || q_full !== 2'b00 || turn_valid !== 2'b00) begin
         bad++; $display("FAIL midq_reset: got pos=%b full=%b tv=%b expected 1111 00 00", next_pos, q_full, turn_valid);
      end
      idle(2);
      rst_n = 1'b1;
      idle(2);
      do_tick();
      total++;
      if (next_pos !== 4'b1111 || turn_valid !== 2'b00) begin
         bad++; $display("FAIL midq_empty: got pos=%b tv=%b expected 1111 00", next_pos, turn_valid);
      end
   endtask

   task automatic test_push_pop();
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b00, 2'b00, 2'b00, 10);
      exp_q0.push_back(2'b10);
      press(2'b00, 2'b00, 2'b01, 2'b00, 10);
      total++;
      if (q_full !== 2'b01) begin bad++; $display("FAIL pp_full_pre: got %b expected 01", q_full); end
      // The request lands on the 7th edge after the raw rise; tick is aligned to that edge.
      down = 2'b01;
      exp_q0.push_back(2'b01);
      idle(6);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      total++;
      if (next_pos !== 4'b1100 || turn_valid !== 2'b01 || q_full !== 2'b01) begin
         bad++; $display("FAIL pp_same_cycle: got pos=%b tv=%b full=%b expected 1100 01 01", next_pos, turn_valid, q_full);
      end
      idle(4);
      down = 2'b00;
      idle(10);
      do_tick();
      total++;
      if (next_pos !== 4'b1110 || q_full !== 2'b00) begin
         bad++; $display("FAIL pp_t2: got pos=%b full=%b expected 1110 00", next_pos, q_full);
      end
      do_tick();
      total++;
      if (next_pos !== 4'b1101 || turn_valid !== 2'b01) begin
         bad++; $display("FAIL pp_t3: got pos=%b tv=%b expected 1101 01", next_pos, turn_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_q0.push_back(2'b10);
      exp_q1.push_back(2'b00);
      press(2'b10, 2'b00, 2'b01, 2'b00, 10);
      exp_q0.push_back(2'b00);
      press(2'b01, 2'b00, 2'b00, 2'b00, 10);
      total++;
      if (q_full !== 2'b01) begin bad++; $display("FAIL b2b_full: got %b expected 01", q_full); end
      tick = 1'b1;
      @(negedge clk);
      total++;
      if (next_pos !== 4'b0010 || turn_valid !== 2'b11) begin
         bad++; $display("FAIL b2b_t1: got pos=%b tv=%b expected 0010 11", next_pos, turn_valid);
      end
      @(negedge clk);
      total++;
      if (next_pos !== 4'b0000 || turn_valid !== 2'b01) begin
         bad++; $display("FAIL b2b_t2: got pos=%b tv=%b expected 0000 01", next_pos, turn_valid);
      end
      @(negedge clk);
      tick = 1'b0;
      total++;
      if (next_pos !== 4'b0000 || turn_valid !== 2'b00) begin
         bad++; $display("FAIL b2b_t3: got pos=%b tv=%b expected 0000 00", next_pos, turn_valid);
      end
      idle(2);
      total++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         bad++; $display("FAIL sb_drain: left p0=%0d p1=%0d expected 0 0", exp_q0.size(), exp_q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_turn();
      test_reverse();
      test_double_turn();
      test_glitch();
      test_priority_reset();
      test_push_pop();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
